// File: rtl/ll_pkg.sv
// Shared definitions for the LocalLink frame transmitter.
// Contents:
//    state_t     - frame sequencer states
//    HEAD_WORDS  - number of header beats per frame
//    HDR_FLAG    - header index carrying the command flag word
//    HDR_LEN     - header index carrying the byte length
//    REM_*       - LocalLink remainder codes for the final payload beat
//    len_to_rem  - maps len[1:0] to the remainder code of the last payload beat
package ll_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HEAD    = 2'd1,
      PAYLOAD = 2'd2,
      FOOT    = 2'd3
   } state_t;

   localparam int HEAD_WORDS = 8;
   localparam int HDR_FLAG   = 4;
   localparam int HDR_LEN    = 5;

   localparam logic [3:0] REM_4B = 4'b0000;
   localparam logic [3:0] REM_3B = 4'b0001;
   localparam logic [3:0] REM_2B = 4'b0011;
   localparam logic [3:0] REM_1B = 4'b0111;

   // A length that is a multiple of 4 fills the last word completely.
   function automatic logic [3:0] len_to_rem(input logic [1:0] len_lsb);
      logic [3:0] r;
      case (len_lsb)
         2'b00:   r = REM_4B;
         2'b11:   r = REM_3B;
         2'b10:   r = REM_2B;
         default: r = REM_1B;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ll_out_stage.sv
// One-entry LocalLink output register.
// Holds one beat (data, remainder, active-low delimiters, active-low source
// ready). A new beat (or a bubble) is loaded whenever the register is empty
// or its current beat transfers; while the destination stalls, every output
// holds.
// Ports:
//    clk, rst        clock, asynchronous active-high reset
//    in_vld          a beat is offered for loading this cycle
//    in_data/in_rem  beat payload and remainder
//    in_sof..in_eop  delimiters for the offered beat (active-high)
//    can_load        the register takes in_* on the next rising edge
//    dst_rdy_n       LocalLink destination ready (active-low)
//    data..src_rdy_n registered LocalLink outputs
module ll_out_stage #(
   parameter int DATA_W = 32,
   parameter int REM_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] in_data,
   input  logic [REM_W-1:0]  in_rem,
   input  logic              in_sof,
   input  logic              in_eof,
   input  logic              in_sop,
   input  logic              in_eop,
   output logic              can_load,
   input  logic              dst_rdy_n,
   output logic [DATA_W-1:0] data,
   output logic [REM_W-1:0]  rem,
   output logic              sof_n,
   output logic              eof_n,
   output logic              sop_n,
   output logic              eop_n,
   output logic              src_rdy_n
);

   // Empty, or the held beat leaves on this edge.
   assign can_load = src_rdy_n | ~dst_rdy_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data      <= '0;
         rem       <= '0;
         sof_n     <= 1'b1;
         eof_n     <= 1'b1;
         sop_n     <= 1'b1;
         eop_n     <= 1'b1;
         src_rdy_n <= 1'b1;
      end else if (can_load) begin
         // Bubbles keep the last data but never carry a delimiter.
         src_rdy_n <= ~in_vld;
         sof_n     <= ~(in_vld & in_sof);
         eof_n     <= ~(in_vld & in_eof);
         sop_n     <= ~(in_vld & in_sop);
         eop_n     <= ~(in_vld & in_eop);
         if (in_vld) begin
            data <= in_data;
            rem  <= in_rem;
         end
      end
   end

endmodule

// File: rtl/ll_frame_tx.sv
// LocalLink TX frame source.
// Accepts a command (flag word, byte length), then emits one frame:
// 8 header words (SOF on word 0, flag on word 4, length on word 5),
// ceil(len/4) payload words (SOP on the first, EOP+REM on the last) and
// FOOTER_WORDS footer words (EOF on the last).
// Ports:
//    CPMDMALLCLK        clock
//    DMALLRSTENGINEACK  asynchronous active-high reset
//    cmd_*              command handshake, flag and byte length
//    pl_*               32-bit big-endian payload stream handshake
//    DMALLTX*           LocalLink source outputs (delimiters active-low)
//    LLDMATXDSTRDYN     LocalLink destination ready (active-low)
//    busy               frame in progress (accept through EOF transfer)
//    done               pulse after the EOF beat transfers
//    err_len0           pulse when a zero-length command is dropped
module ll_frame_tx
   import ll_pkg::*;
#(
   parameter int FOOTER_WORDS = 1
) (
   input  logic        CPMDMALLCLK,
   input  logic        DMALLRSTENGINEACK,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_flag,
   input  logic [31:0] cmd_len,
   input  logic [31:0] pl_data,
   input  logic        pl_valid,
   output logic        pl_ready,
   output logic [31:0] DMALLTXD,
   output logic [3:0]  DMALLTXREM,
   output logic        DMALLTXSOFN,
   output logic        DMALLTXEOFN,
   output logic        DMALLTXSOPN,
   output logic        DMALLTXEOPN,
   output logic        DMALLTXSRCRDYN,
   input  logic        LLDMATXDSTRDYN,
   output logic        busy,
   output logic        done,
   output logic        err_len0
);

   localparam logic [2:0] HEAD_LAST = 3'(HEAD_WORDS - 1);
   localparam logic [3:0] FOOT_LAST = 4'(FOOTER_WORDS - 1);

   state_t      state, state_nxt;
   logic [2:0]  hcnt, hcnt_nxt;
   logic [29:0] words_left, words_left_nxt;
   logic [3:0]  fcnt, fcnt_nxt;
   logic        foot_loaded, foot_loaded_nxt;
   logic        first, first_nxt;
   logic [31:0] flag_q, flag_nxt;
   logic [31:0] len_q, len_nxt;
   logic        armed;
   logic        done_nxt, err_nxt;

   logic        can_load;
   logic        ld_vld;
   logic [31:0] ld_data;
   logic [3:0]  ld_rem;
   logic        ld_sof, ld_eof, ld_sop, ld_eop;
   logic        eof_xfer;

   assign eof_xfer = ~DMALLTXSRCRDYN & ~LLDMATXDSTRDYN & ~DMALLTXEOFN;
   assign busy     = (state != IDLE);

   // Sequencer state
   always_ff @(posedge CPMDMALLCLK or posedge DMALLRSTENGINEACK) begin
      if (DMALLRSTENGINEACK) begin
         state       <= IDLE;
         hcnt        <= '0;
         words_left  <= '0;
         fcnt        <= '0;
         foot_loaded <= 1'b0;
         first       <= 1'b0;
         flag_q      <= '0;
         len_q       <= '0;
         armed       <= 1'b0;
         done        <= 1'b0;
         err_len0    <= 1'b0;
      end else begin
         state       <= state_nxt;
         hcnt        <= hcnt_nxt;
         words_left  <= words_left_nxt;
         fcnt        <= fcnt_nxt;
         foot_loaded <= foot_loaded_nxt;
         first       <= first_nxt;
         flag_q      <= flag_nxt;
         len_q       <= len_nxt;
         armed       <= 1'b1;
         done        <= done_nxt;
         err_len0    <= err_nxt;
      end
   end

   // Next-state and beat generation
   always_comb begin
      state_nxt       = state;
      hcnt_nxt        = hcnt;
      words_left_nxt  = words_left;
      fcnt_nxt        = fcnt;
      foot_loaded_nxt = foot_loaded;
      first_nxt       = first;
      flag_nxt        = flag_q;
      len_nxt         = len_q;
      done_nxt        = 1'b0;
      err_nxt         = 1'b0;
      cmd_ready       = 1'b0;
      pl_ready        = 1'b0;
      ld_vld          = 1'b0;
      ld_data         = '0;
      ld_rem          = REM_4B;
      ld_sof          = 1'b0;
      ld_eof          = 1'b0;
      ld_sop          = 1'b0;
      ld_eop          = 1'b0;

      case (state)
         IDLE: begin
            cmd_ready = armed & can_load;
            if (cmd_valid && cmd_ready) begin
               if (cmd_len == 32'd0) begin
                  err_nxt = 1'b1;
               end else begin
                  // Header word 0 is loaded on the accept edge so it is
                  // on the bus in the very next cycle.
                  flag_nxt       = cmd_flag;
                  len_nxt        = cmd_len;
                  words_left_nxt = cmd_len[31:2] + 30'(|cmd_len[1:0]);
                  first_nxt      = 1'b1;
                  ld_vld         = 1'b1;
                  ld_sof         = 1'b1;
                  hcnt_nxt       = 3'd1;
                  state_nxt      = HEAD;
               end
            end
         end

         HEAD: begin
            if (can_load) begin
               ld_vld = 1'b1;
               if (hcnt == 3'(HDR_FLAG))
                  ld_data = flag_q;
               else if (hcnt == 3'(HDR_LEN))
                  ld_data = len_q;
               hcnt_nxt = hcnt + 3'd1;
               if (hcnt == HEAD_LAST)
                  state_nxt = PAYLOAD;
            end
         end

         PAYLOAD: begin
            pl_ready = can_load;
            if (can_load && pl_valid) begin
               ld_vld         = 1'b1;
               ld_data        = pl_data;
               ld_sop         = first;
               first_nxt      = 1'b0;
               words_left_nxt = words_left - 30'd1;
               if (words_left == 30'd1) begin
                  ld_eop          = 1'b1;
                  ld_rem          = len_to_rem(len_q[1:0]);
                  fcnt_nxt        = '0;
                  foot_loaded_nxt = 1'b0;
                  state_nxt       = FOOT;
               end
            end
         end

         FOOT: begin
            // After the EOF word is loaded, only bubbles follow until it
            // leaves; its transfer ends the frame.
            if (!foot_loaded && can_load) begin
               ld_vld = 1'b1;
               if (fcnt == FOOT_LAST) begin
                  ld_eof          = 1'b1;
                  foot_loaded_nxt = 1'b1;
               end else begin
                  fcnt_nxt = fcnt + 4'd1;
               end
            end
            if (eof_xfer) begin
               done_nxt        = 1'b1;
               foot_loaded_nxt = 1'b0;
               state_nxt       = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   // Output register stage
   ll_out_stage #(
      .DATA_W (32),
      .REM_W  (4)
   ) u_out (
      .clk       (CPMDMALLCLK),
      .rst       (DMALLRSTENGINEACK),
      .in_vld    (ld_vld),
      .in_data   (ld_data),
      .in_rem    (ld_rem),
      .in_sof    (ld_sof),
      .in_eof    (ld_eof),
      .in_sop    (ld_sop),
      .in_eop    (ld_eop),
      .can_load  (can_load),
      .dst_rdy_n (LLDMATXDSTRDYN),
      .data      (DMALLTXD),
      .rem       (DMALLTXREM),
      .sof_n     (DMALLTXSOFN),
      .eof_n     (DMALLTXEOFN),
      .sop_n     (DMALLTXSOPN),
      .eop_n     (DMALLTXEOPN),
      .src_rdy_n (DMALLTXSRCRDYN)
   );

endmodule

// File: tb/tb_ll_frame_tx.sv
module tb_ll_frame_tx;

   localparam int FW = 1;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  r;
      logic        sof;
      logic        eof;
      logic        sop;
      logic        eop;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_flag;
   logic [31:0] cmd_len;
   logic [31:0] pl_data;
   logic        pl_valid;
   logic        pl_ready;
   logic [31:0] txd;
   logic [3:0]  txrem;
   logic        sofn, eofn, sopn, eopn, srcrdyn;
   logic        dstrdyn;
   logic        busy, done, err_len0;

   always #5 clk = ~clk;

   ll_frame_tx #(.FOOTER_WORDS(FW)) dut (
      .CPMDMALLCLK       (clk),
      .DMALLRSTENGINEACK (rst),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_flag          (cmd_flag),
      .cmd_len           (cmd_len),
      .pl_data           (pl_data),
      .pl_valid          (pl_valid),
      .pl_ready          (pl_ready),
      .DMALLTXD          (txd),
      .DMALLTXREM        (txrem),
      .DMALLTXSOFN       (sofn),
      .DMALLTXEOFN       (eofn),
      .DMALLTXSOPN       (sopn),
      .DMALLTXEOPN       (eopn),
      .DMALLTXSRCRDYN    (srcrdyn),
      .LLDMATXDSTRDYN    (dstrdyn),
      .busy              (busy),
      .done              (done),
      .err_len0          (err_len0)
   );

   int          checks = 0;
   int          errors = 0;

   beat_t       got_q[$];
   beat_t       exp_q[$];
   logic [31:0] pl_q[$];
   logic [31:0] pw[16];

   int          cyc = 0;
   int          eof_cyc, done_cyc, done_cnt, bubbles, hold_err;
   bit          bp_mode = 1'b0;
   int          gap_after = -1;
   int          gap_cycles = 3;
   int          gap_cnt = 0;
   int          pl_sent = 0;
   bit          timed_out;
   logic        first_src, first_sof, first_busy;

   // Bus monitor: samples on the falling edge, records transferred beats.
   initial begin
      beat_t cur, prev;
      bit    prev_stall;
      prev_stall = 1'b0;
      prev = '0;
      forever begin
         @(negedge clk);
         cyc++;
         cur.d = txd; cur.r = txrem;
         cur.sof = ~sofn; cur.eof = ~eofn; cur.sop = ~sopn; cur.eop = ~eopn;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && (srcrdyn !== 1'b0 || cur !== prev)) hold_err++;
            prev_stall = (srcrdyn == 1'b0 && dstrdyn == 1'b1);
            prev = cur;
            if (srcrdyn == 1'b0 && dstrdyn == 1'b0) begin
               got_q.push_back(cur);
               if (eofn == 1'b0) eof_cyc = cyc;
            end
            if (busy && srcrdyn) bubbles++;
            if (done) begin
               done_cyc = cyc;
               done_cnt++;
            end
         end
      end
   end

   // Payload feeder with optional gap after word gap_after.
   initial begin
      bit take;
      pl_valid = 1'b0;
      pl_data  = '0;
      forever begin
         @(negedge clk);
         take = pl_valid && pl_ready;
         @(posedge clk);
         #1;
         if (take && pl_q.size() > 0) begin
            pl_q.delete(0);
            pl_sent++;
            if (pl_sent == gap_after) gap_cnt = gap_cycles;
         end
         if (gap_cnt > 0) begin
            pl_valid = 1'b0;
            gap_cnt--;
         end else if (pl_q.size() > 0) begin
            pl_valid = 1'b1;
            pl_data  = pl_q[0];
         end else begin
            pl_valid = 1'b0;
         end
      end
   end

   // Destination ready: held ready, or toggled every cycle.
   initial begin
      dstrdyn = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) dstrdyn = ~dstrdyn;
         else         dstrdyn = 1'b0;
      end
   end

   function automatic logic [3:0] exp_rem(input logic [31:0] len);
      case (len[1:0])
         2'd0:    return 4'b0000;
         2'd3:    return 4'b0001;
         2'd2:    return 4'b0011;
         default: return 4'b0111;
      endcase
   endfunction

   task automatic build_expected(input logic [31:0] flag, input logic [31:0] len, input int nw);
      beat_t b;
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         b = '0;
         b.sof = (i == 0);
         if (i == 4) b.d = flag;
         if (i == 5) b.d = len;
         exp_q.push_back(b);
      end
      for (int i = 0; i < nw; i++) begin
         b = '0;
         b.d   = pw[i];
         b.sop = (i == 0);
         b.eop = (i == nw - 1);
         if (i == nw - 1) b.r = exp_rem(len);
         exp_q.push_back(b);
      end
      for (int i = 0; i < FW; i++) begin
         b = '0;
         b.eof = (i == FW - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic send_cmd(input logic [31:0] flag, input logic [31:0] len);
      bit acc;
      acc = 1'b0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_flag  = flag;
      cmd_len   = len;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         if (cmd_ready) acc = 1'b1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      if (!acc) timed_out = 1'b1;
   endtask

   task automatic drive_frame(input logic [31:0] flag, input logic [31:0] len,
                              input int nw, input bit bp, input int gap);
      got_q.delete();
      pl_q.delete();
      for (int i = 0; i < nw; i++) pl_q.push_back(pw[i]);
      pl_sent   = 0;
      gap_after = gap;
      bubbles   = 0;
      done_cnt  = 0;
      hold_err  = 0;
      eof_cyc   = -1;
      done_cyc  = -2;
      timed_out = 1'b0;
      build_expected(flag, len, nw);
      bp_mode = bp;
      send_cmd(flag, len);
      @(negedge clk);
      first_src  = srcrdyn;
      first_sof  = sofn;
      first_busy = busy;
      for (int i = 0; i < 400 && done_cnt == 0; i++) @(negedge clk);
      if (done_cnt == 0) timed_out = 1'b1;
      bp_mode   = 1'b0;
      gap_after = -1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_flag = '0; cmd_len = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({srcrdyn, sofn, eofn, sopn, eopn} !== 5'b11111) begin
         errors++; $display("FAIL reset_delims got %b want 11111", {srcrdyn, sofn, eofn, sopn, eopn});
      end
      checks++;
      if ({txd, txrem} !== 36'h0) begin
         errors++; $display("FAIL reset_data got %h want 0", {txd, txrem});
      end
      checks++;
      if ({cmd_ready, pl_ready, busy, done, err_len0} !== 5'b00000) begin
         errors++; $display("FAIL reset_ctrl got %b want 00000", {cmd_ready, pl_ready, busy, done, err_len0});
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_cmd_ready got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_basic;
      pw[0] = 32'hA1A2_A3A4; pw[1] = 32'hB1B2_B3B4; pw[2] = 32'hC1C2_C3C4;
      drive_frame(32'h2000_0000, 32'd10, 3, 1'b0, -1);
      checks++;
      if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout got %b want 0", timed_out); end
      checks++;
      if ({first_src, first_sof, first_busy} !== 3'b001) begin
         errors++; $display("FAIL basic_latency got %b want 001", {first_src, first_sof, first_busy});
      end
      checks++;
      if (got_q.size() !== 12) begin errors++; $display("FAIL basic_beats got %0d want 12", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL basic_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      if (got_q.size() == 12) begin
         checks++;
         if (got_q[4].d !== 32'h2000_0000 || got_q[5].d !== 32'h0000_000A) begin
            errors++; $display("FAIL basic_hdr45 got %h %h want 20000000 0000000a", got_q[4].d, got_q[5].d);
         end
         checks++;
         if ({got_q[10].eop, got_q[10].r, got_q[8].sop, got_q[11].eof} !== 7'b1_0011_1_1) begin
            errors++; $display("FAIL basic_delims got %b want 1001111",
                               {got_q[10].eop, got_q[10].r, got_q[8].sop, got_q[11].eof});
         end
      end
      checks++;
      if (done_cyc !== eof_cyc + 1) begin
         errors++; $display("FAIL basic_done_timing got %0d want %0d", done_cyc, eof_cyc + 1);
      end
      checks++;
      if (done_cnt !== 1) begin errors++; $display("FAIL basic_done_width got %0d want 1", done_cnt); end
      checks++;
      if (bubbles !== 0) begin errors++; $display("FAIL basic_bubbles got %0d want 0", bubbles); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
   endtask

   task automatic test_len_sweep;
      logic [3:0] rems[4];
      rems[0] = 4'b0111; rems[1] = 4'b0011; rems[2] = 4'b0001; rems[3] = 4'b0000;
      for (int l = 1; l <= 4; l++) begin
         pw[0] = 32'h5500_0000 + l;
         drive_frame(32'h0000_0001, 32'(l), 1, 1'b0, -1);
         checks++;
         if (got_q.size() !== 10 || timed_out) begin
            errors++; $display("FAIL sweep%0d_beats got %0d want 10", l, got_q.size());
         end else begin
            checks++;
            if ({got_q[8].sop, got_q[8].eop, got_q[8].r, got_q[8].d} !== {2'b11, rems[l-1], pw[0]}) begin
               errors++; $display("FAIL sweep%0d_payload got %b %b %h want 11 %b %h", l,
                                  got_q[8].sop, got_q[8].eop, got_q[8].r, rems[l-1], pw[0]);
            end
            checks++;
            if (got_q[5].d !== 32'(l)) begin
               errors++; $display("FAIL sweep%0d_hdrlen got %h want %h", l, got_q[5].d, 32'(l));
            end
         end
      end
   endtask

   task automatic test_backpressure;
      pw[0] = 32'hA1A2_A3A4; pw[1] = 32'hB1B2_B3B4; pw[2] = 32'hC1C2_C3C4;
      drive_frame(32'h2000_0000, 32'd10, 3, 1'b1, -1);
      checks++;
      if (timed_out !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b want 0", timed_out); end
      checks++;
      if (got_q.size() !== 12) begin errors++; $display("FAIL bp_beats got %0d want 12", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL bp_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      checks++;
      if (hold_err !== 0) begin errors++; $display("FAIL bp_hold got %0d want 0", hold_err); end
   endtask

   task automatic test_payload_gap;
      for (int i = 0; i < 5; i++) pw[i] = 32'h1000_0000 * (i + 1) + 32'h77;
      drive_frame(32'h0000_0000, 32'd19, 5, 1'b0, 2);
      checks++;
      if (timed_out !== 1'b0) begin errors++; $display("FAIL gap_timeout got %b want 0", timed_out); end
      checks++;
      if (bubbles !== 3) begin errors++; $display("FAIL gap_bubbles got %0d want 3", bubbles); end
      checks++;
      if (got_q.size() !== 14) begin errors++; $display("FAIL gap_beats got %0d want 14", got_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL gap_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
      if (got_q.size() == 14) begin
         checks++;
         if (got_q[12].r !== 4'b0001) begin
            errors++; $display("FAIL gap_rem got %b want 0001", got_q[12].r);
         end
      end
   endtask

   task automatic test_zero_len;
      int src_seen;
      timed_out = 1'b0;
      send_cmd(32'hFFFF_FFFF, 32'd0);
      @(negedge clk);
      checks++;
      if ({err_len0, srcrdyn, busy} !== 3'b110) begin
         errors++; $display("FAIL zero_pulse got %b want 110", {err_len0, srcrdyn, busy});
      end
      src_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (srcrdyn !== 1'b1 || err_len0 !== 1'b0) src_seen++;
      end
      checks++;
      if (src_seen !== 0 || timed_out) begin
         errors++; $display("FAIL zero_quiet got %0d want 0", src_seen);
      end
      pw[0] = 32'hDEAD_BEEF; pw[1] = 32'hCAFE_F00D;
      drive_frame(32'h0000_0002, 32'd8, 2, 1'b0, -1);
      checks++;
      if (got_q.size() !== 11 || timed_out) begin
         errors++; $display("FAIL zero_next_beats got %0d want 11", got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL zero_next_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid;
      bit reached;
      for (int i = 0; i < 4; i++) pw[i] = 32'h0BAD_0000 + i;
      got_q.delete();
      pl_q.delete();
      for (int i = 0; i < 4; i++) pl_q.push_back(pw[i]);
      timed_out = 1'b0;
      send_cmd(32'h0, 32'd16);
      reached = 1'b0;
      for (int i = 0; i < 100 && !reached; i++) begin
         @(negedge clk);
         if (got_q.size() >= 10) reached = 1'b1;
      end
      checks++;
      if (!reached || timed_out) begin
         errors++; $display("FAIL rstmid_reach got %0d want 10", got_q.size());
      end
      @(posedge clk);
      #2 rst = 1'b1;
      pl_q.delete();
      #1;
      checks++;
      if ({srcrdyn, sofn, eofn, sopn, eopn} !== 5'b11111) begin
         errors++; $display("FAIL rstmid_delims got %b want 11111", {srcrdyn, sofn, eofn, sopn, eopn});
      end
      checks++;
      if ({busy, cmd_ready, pl_ready} !== 3'b000) begin
         errors++; $display("FAIL rstmid_ctrl got %b want 000", {busy, cmd_ready, pl_ready});
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || srcrdyn !== 1'b1) begin
         errors++; $display("FAIL rstmid_release got %b%b want 11", cmd_ready, srcrdyn);
      end
      pw[0] = 32'h1234_5678;
      drive_frame(32'h2000_0000, 32'd4, 1, 1'b0, -1);
      checks++;
      if (got_q.size() !== 10 || timed_out) begin
         errors++; $display("FAIL rstmid_next_beats got %0d want 10", got_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rstmid_next_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_sweep();
      test_backpressure();
      test_payload_gap();
      test_zero_len();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
